cache_mem_arb: RTL and testbench
================================

Name: cache_mem_arb

Overview:
- Arbiter and sequencer for the single-port cache data SRAM, which is shared by three requesters:
  - the read controller (word reads);
  - the write controller (word writes);
  - the fetch engine (line fill writes and victim writeback reads).
- Grants at most one SRAM access per cycle.
- Tracks in-flight reads through a fixed-latency return pipe and routes returned data to the owning requester.

Parameters:
- data_width, 32, SRAM word width.
- list_depth, 4, number of cache lines.
- list_width, 32, words per line. SRAM address width is AW = $clog2(list_depth)+$clog2(list_width).
- rd_lat, 1, SRAM read latency in cycles (>=1).
- starve_limit, 8, wait cycles before a rd/wr requester is promoted above all others (>=2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rd_ren  in  1  read-controller read request
- rd_raddr  in  AW  read address {tag,word}
- rd_rpri  in  2  read priority; nonzero means urgent
- rd_rready  out  1  read request granted this cycle
- rd_rdata  out  data_width  read return data
- rd_rdata_valid  out  1  rd_rdata valid
- wr_wen  in  1  write-controller write request
- wr_waddr  in  AW  write address
- wr_wdata  in  data_width  write data
- wr_wready  out  1  write request granted this cycle
- fe_req  in  1  fetch-engine request
- fe_we  in  1  1 = write (fill), 0 = read (writeback)
- fe_addr  in  AW  fetch address
- fe_wdata  in  data_width  fill write data
- fe_ready  out  1  fetch request granted this cycle
- fe_rdata  out  data_width  writeback read data
- fe_rdata_valid  out  1  fe_rdata valid
- sram_ce  out  1  SRAM chip enable
- sram_we  out  1  SRAM write enable
- sram_addr  out  AW  SRAM address
- sram_wdata  out  data_width  SRAM write data
- sram_rdata  in  data_width  SRAM read data, valid rd_lat cycles after a read ce

Behaviour:
- Handshake:
  - Valid/ready per port; a transfer occurs on req && ready in the same cycle.
  - Requesters hold request, address and data stable until ready.
  - Ready is combinational; at most one ready is high per cycle.
- SRAM drive:
  - sram_ce = 1 exactly in cycles with a grant.
  - sram_we, sram_addr and sram_wdata come from the granted port.
  - When no grant: ce=0, we=0, addr=0, wdata=0.
- Grant priority, evaluated each cycle, highest first:
  1. A starved rd/wr requester. If both are starved, break the tie with the rr flag.
  2. fe_req.
  3. rd_ren with rd_rpri != 0.
  4. rd vs wr by rr flag: rr=0 prefers rd, rr=1 prefers wr.
  - A lone requester is always granted.
- rr flag:
  - Reset value 0.
  - Set to 1 after an rd grant, cleared to 0 after a wr grant.
  - Unchanged on a fetch grant or an idle cycle.
- Starvation counters (rd_wait, wr_wait):
  - Width $clog2(starve_limit+1).
  - Increment when requesting and not granted; saturate at starve_limit.
  - Clear on grant or when the request is deasserted.
  - Starved means counter == starve_limit.
- Read return pipe:
  - A shift register of depth rd_lat carrying {valid, owner}, with owner in {RD, FE}.
  - Pushed on every granted read; writes push valid=0.
  - At the pipe output, owner RD drives rd_rdata_valid=1 and owner FE drives fe_rdata_valid=1. Both data outputs carry sram_rdata.
  - rd_rdata_valid rises exactly rd_lat cycles after the rd handshake. Back-to-back reads return back-to-back in grant order.
- Hazards:
  - A read and a write to the same address in the same cycle are serialised by grant order. A read granted the cycle after a write returns the new data.
- Reset:
  - Asynchronous clear of the return pipe, rr, and both wait counters.
  - All outputs read 0 during and after reset until a request arrives.
  - In-flight reads at reset are dropped; no valid is issued for them afterwards.
- No FSM beyond the rr flag, counters and pipe. The arbiter grants any cycle; reads and writes may interleave freely.

Decomposition:
- cache_pkg holds:
  - typedef enum logic [1:0] mem_owner_t {OWN_NONE, OWN_RD, OWN_WR, OWN_FE};
  - mem_rpri encoding constants (PRI_NORM=2'b00);
  - the AW helper function.
- Sub-module cache_mem_rtn_pipe: parameterised rd_lat shift register of {valid, mem_owner_t} with asynchronous clear.
- The arbitration logic stays in cache_mem_arb.

Test Plan:
- rd_ren=1 only, rd_raddr=0x25, SRAM word 0x25 preloaded with 0xDEADBEEF, rd_lat=1 -> rd_rready=1 in cycle 0; rd_rdata_valid=1 with rd_rdata=0xDEADBEEF in cycle 1; fe_rdata_valid=0.
- rd_ren and wr_wen held together for 4 cycles, rpri=0, from reset -> grants alternate rd, wr, rd, wr; sram_we=0,1,0,1.
- fe_req=1 (fe_we=1) held 20 cycles with wr_wen=1 -> fe granted for 8 cycles; wr granted in cycle 8 (starved); fe resumes in cycle 9.
- rd_ren with rd_rpri=2'b01 plus wr_wen, rr=1 -> rd granted first despite rr.
- Fetch read at addr 0x40, then rd read at 0x41 in consecutive cycles -> fe_rdata_valid then rd_rdata_valid on consecutive cycles, with the correct words.
- rst_n pulled low one cycle after an rd grant with rd_lat=2 -> no rd_rdata_valid ever; all outputs 0; rr=0 after release.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache data SRAM arbiter and its return pipe.
package cache_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_RD   = 2'd1,
    OWN_WR   = 2'd2,
    OWN_FE   = 2'd3
  } mem_owner_t;

  // Read priority encoding; anything other than PRI_NORM is urgent.
  localparam logic [1:0] PRI_NORM = 2'b00;
  localparam logic [1:0] PRI_URG  = 2'b01;

  typedef struct packed {
    logic       valid;
    mem_owner_t owner;
  } rtn_ent_t;

  function automatic int calc_aw(input int depth, input int width);
    return $clog2(depth) + $clog2(width);
  endfunction

endpackage

// File: rtl/cache_mem_rtn_pipe.sv
// Fixed-latency shift register tracking which requester owns each in-flight SRAM read.
module cache_mem_rtn_pipe
  import cache_pkg::*;
#(
  parameter int rd_lat = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  rtn_ent_t push,
  output rtn_ent_t pop
);

  rtn_ent_t stage [rd_lat];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < rd_lat; i++) stage[i] <= '0;
    end else begin
      stage[0] <= push;
      for (int i = 1; i < rd_lat; i++) stage[i] <= stage[i-1];
    end
  end

  assign pop = stage[rd_lat-1];

endmodule

// File: rtl/cache_mem_arb.sv
// Single-port cache data SRAM arbiter: one grant per cycle among read, write and
// fetch requesters, with starvation promotion and routing of read return data.
module cache_mem_arb
  import cache_pkg::*;
#(
  parameter  int data_width   = 32,
  parameter  int list_depth   = 4,
  parameter  int list_width   = 32,
  parameter  int rd_lat       = 1,
  parameter  int starve_limit = 8,
  localparam int AW           = calc_aw(list_depth, list_width)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_ren,
  input  logic [AW-1:0]         rd_raddr,
  input  logic [1:0]            rd_rpri,
  output logic                  rd_rready,
  output logic [data_width-1:0] rd_rdata,
  output logic                  rd_rdata_valid,
  input  logic                  wr_wen,
  input  logic [AW-1:0]         wr_waddr,
  input  logic [data_width-1:0] wr_wdata,
  output logic                  wr_wready,
  input  logic                  fe_req,
  input  logic                  fe_we,
  input  logic [AW-1:0]         fe_addr,
  input  logic [data_width-1:0] fe_wdata,
  output logic                  fe_ready,
  output logic [data_width-1:0] fe_rdata,
  output logic                  fe_rdata_valid,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [AW-1:0]         sram_addr,
  output logic [data_width-1:0] sram_wdata,
  input  logic [data_width-1:0] sram_rdata
);

  localparam int            WW   = $clog2(starve_limit + 1);
  localparam logic [WW-1:0] SLIM = WW'(starve_limit);

  logic [WW-1:0] rd_wait;
  logic [WW-1:0] wr_wait;
  logic          rr;
  logic          rd_starved;
  logic          wr_starved;
  mem_owner_t    grant;
  rtn_ent_t      rtn_push;
  rtn_ent_t      rtn_pop;

  // A counter can still read SLIM the cycle its request drops, so qualify with the request.
  assign rd_starved = rd_ren && (rd_wait == SLIM);
  assign wr_starved = wr_wen && (wr_wait == SLIM);

  always_comb begin
    grant = OWN_NONE;
    if (rd_starved && wr_starved)      grant = rr ? OWN_WR : OWN_RD;
    else if (rd_starved)               grant = OWN_RD;
    else if (wr_starved)               grant = OWN_WR;
    else if (fe_req)                   grant = OWN_FE;
    else if (rd_ren && (rd_rpri != PRI_NORM)) grant = OWN_RD;
    else if (rd_ren && wr_wen)         grant = rr ? OWN_WR : OWN_RD;
    else if (rd_ren)                   grant = OWN_RD;
    else if (wr_wen)                   grant = OWN_WR;
  end

  assign rd_rready = (grant == OWN_RD);
  assign wr_wready = (grant == OWN_WR);
  assign fe_ready  = (grant == OWN_FE);

  always_comb begin
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    case (grant)
      OWN_RD: begin
        sram_ce   = 1'b1;
        sram_addr = rd_raddr;
      end
      OWN_WR: begin
        sram_ce    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = wr_waddr;
        sram_wdata = wr_wdata;
      end
      OWN_FE: begin
        sram_ce    = 1'b1;
        sram_we    = fe_we;
        sram_addr  = fe_addr;
        sram_wdata = fe_we ? fe_wdata : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_wait <= '0;
      wr_wait <= '0;
      rr      <= 1'b0;
    end else begin
      if (!rd_ren || rd_rready)  rd_wait <= '0;
      else if (rd_wait != SLIM)  rd_wait <= rd_wait + 1'b1;

      if (!wr_wen || wr_wready)  wr_wait <= '0;
      else if (wr_wait != SLIM)  wr_wait <= wr_wait + 1'b1;

      if (rd_rready)      rr <= 1'b1;
      else if (wr_wready) rr <= 1'b0;
    end
  end

  always_comb begin
    rtn_push.valid = rd_rready || (fe_ready && !fe_we);
    rtn_push.owner = rd_rready ? OWN_RD : (rtn_push.valid ? OWN_FE : OWN_NONE);
  end

  cache_mem_rtn_pipe #(
    .rd_lat (rd_lat)
  ) u_rtn_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rtn_push),
    .pop   (rtn_pop)
  );

  // Data outputs are held at zero outside valid cycles so idle outputs read 0.
  assign rd_rdata_valid = rtn_pop.valid && (rtn_pop.owner == OWN_RD);
  assign fe_rdata_valid = rtn_pop.valid && (rtn_pop.owner == OWN_FE);
  assign rd_rdata       = rd_rdata_valid ? sram_rdata : '0;
  assign fe_rdata       = fe_rdata_valid ? sram_rdata : '0;

endmodule

// File: tb/tb_cache_mem_arb.sv
// Bench for cache_mem_arb: a rd_lat=1 instance checked throughout and a rd_lat=2
// instance sharing the same stimulus for the reset-drop case.
module tb_cache_mem_arb;
  import cache_pkg::*;

  localparam int DW = 32;
  localparam int AW = 7;

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          rd_ren, wr_wen, fe_req, fe_we;
  logic [AW-1:0] rd_raddr, wr_waddr, fe_addr;
  logic [1:0]    rd_rpri;
  logic [DW-1:0] wr_wdata, fe_wdata;

  logic          rd_rready, wr_wready, fe_ready, rd_rdata_valid, fe_rdata_valid;
  logic [DW-1:0] rd_rdata, fe_rdata, sram_wdata, sram_rdata;
  logic          sram_ce, sram_we;
  logic [AW-1:0] sram_addr;

  logic          l2_rd_rready, l2_wr_wready, l2_fe_ready, l2_rd_rdata_valid, l2_fe_rdata_valid;
  logic [DW-1:0] l2_rd_rdata, l2_fe_rdata, l2_sram_wdata, l2_sram_rdata, l2_q0;
  logic          l2_sram_ce, l2_sram_we;
  logic [AW-1:0] l2_sram_addr;

  cache_mem_arb #(.data_width(DW), .list_depth(4), .list_width(32), .rd_lat(1), .starve_limit(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_ren(rd_ren), .rd_raddr(rd_raddr), .rd_rpri(rd_rpri), .rd_rready(rd_rready),
    .rd_rdata(rd_rdata), .rd_rdata_valid(rd_rdata_valid),
    .wr_wen(wr_wen), .wr_waddr(wr_waddr), .wr_wdata(wr_wdata), .wr_wready(wr_wready),
    .fe_req(fe_req), .fe_we(fe_we), .fe_addr(fe_addr), .fe_wdata(fe_wdata), .fe_ready(fe_ready),
    .fe_rdata(fe_rdata), .fe_rdata_valid(fe_rdata_valid),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  cache_mem_arb #(.data_width(DW), .list_depth(4), .list_width(32), .rd_lat(2), .starve_limit(8)) dut_l2 (
    .clk(clk), .rst_n(rst_n),
    .rd_ren(rd_ren), .rd_raddr(rd_raddr), .rd_rpri(rd_rpri), .rd_rready(l2_rd_rready),
    .rd_rdata(l2_rd_rdata), .rd_rdata_valid(l2_rd_rdata_valid),
    .wr_wen(wr_wen), .wr_waddr(wr_waddr), .wr_wdata(wr_wdata), .wr_wready(l2_wr_wready),
    .fe_req(fe_req), .fe_we(fe_we), .fe_addr(fe_addr), .fe_wdata(fe_wdata), .fe_ready(l2_fe_ready),
    .fe_rdata(l2_fe_rdata), .fe_rdata_valid(l2_fe_rdata_valid),
    .sram_ce(l2_sram_ce), .sram_we(l2_sram_we), .sram_addr(l2_sram_addr), .sram_wdata(l2_sram_wdata),
    .sram_rdata(l2_sram_rdata)
  );

  // SRAM models; preload is refreshed every reset cycle
  logic [DW-1:0] mem [128];
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[7'h25] <= 32'hDEADBEEF;
      mem[7'h10] <= 32'hA5A50010;
      mem[7'h40] <= 32'h40404040;
      mem[7'h41] <= 32'h41414141;
    end else if (sram_ce && sram_we) begin
      mem[sram_addr] <= sram_wdata;
    end
    if (sram_ce && !sram_we) sram_rdata <= mem[sram_addr];
  end

  always @(posedge clk) begin
    if (l2_sram_ce && !l2_sram_we) l2_q0 <= mem[l2_sram_addr];
    l2_sram_rdata <= l2_q0;
  end

  // scoreboard
  int vectors = 0;
  int miscompares = 0;
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] got;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW+1:0] ent(input mem_owner_t o, input logic [DW-1:0] d);
    return {o, d};
  endfunction

  always @(negedge clk) begin
    if (rd_rdata_valid || fe_rdata_valid) begin
      if (rd_rdata_valid && fe_rdata_valid) chk("rtn_both_valid", 1, 0);
      got = rd_rdata_valid ? {OWN_RD, rd_rdata} : {OWN_FE, fe_rdata};
      if (exp_q.size() == 0) chk("rtn_unexpected", got, 0);
      else chk("rtn_data", got, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_grant(input string tag, input logic r, input logic w, input logic f);
    #1;
    chk({tag, "_rd_rready"}, rd_rready, r);
    chk({tag, "_wr_wready"}, wr_wready, w);
    chk({tag, "_fe_ready"},  fe_ready,  f);
    chk({tag, "_sram_ce"},   sram_ce,   r | w | f);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_dut_outs"}, {rd_rready, wr_wready, fe_ready, rd_rdata_valid, fe_rdata_valid,
                             sram_ce, sram_we, sram_addr, sram_wdata, rd_rdata, fe_rdata}, 0);
    chk({tag, "_l2_outs"}, {l2_rd_rready, l2_wr_wready, l2_fe_ready, l2_rd_rdata_valid,
                            l2_fe_rdata_valid, l2_sram_ce, l2_sram_we, l2_sram_addr}, 0);
    chk({tag, "_l2_data"}, {l2_sram_wdata, l2_rd_rdata, l2_fe_rdata}, 0);
  endtask

  task automatic idle_inputs();
    rd_ren = 0; wr_wen = 0; fe_req = 0; fe_we = 0; rd_rpri = PRI_NORM;
    rd_raddr = '0; wr_waddr = '0; fe_addr = '0; wr_wdata = '0; fe_wdata = '0;
  endtask

  task automatic do_reset(input string tag);
    idle_inputs();
    rst_n = 0;
    tick();
    tick();
    #1;
    chk_idle(tag);
    rst_n = 1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst_n = 0;
    do_reset("rst0");

    // lone read returns preloaded word one cycle later
    rd_ren = 1; rd_raddr = 7'h25;
    exp_grant("t1", 1, 0, 0);
    chk("t1_we", sram_we, 0);
    chk("t1_addr", sram_addr, 7'h25);
    exp_q.push_back(ent(OWN_RD, 32'hDEADBEEF));
    tick();
    rd_ren = 0;
    #1;
    chk("t1_rvalid", rd_rdata_valid, 1);
    chk("t1_rdata", rd_rdata, 32'hDEADBEEF);
    chk("t1_fvalid", fe_rdata_valid, 0);
    tick();

    // rd/wr round robin from reset
    do_reset("rst1");
    rd_ren = 1; rd_raddr = 7'h10; wr_wen = 1; wr_waddr = 7'h11; wr_wdata = 32'h00001111;
    for (int i = 0; i < 4; i++) begin
      exp_grant("t2", (i % 2) == 0, (i % 2) == 1, 0);
      chk("t2_we", sram_we, (i % 2) == 1);
      if ((i % 2) == 0) exp_q.push_back(ent(OWN_RD, 32'hA5A50010));
      tick();
    end
    idle_inputs();

    // fetch hogs the port; write is promoted each time it starves
    fe_req = 1; fe_we = 1; fe_addr = 7'h30; fe_wdata = 32'hF0F0F0F0;
    wr_wen = 1; wr_waddr = 7'h31; wr_wdata = 32'h31313131;
    for (int i = 0; i < 20; i++) begin
      exp_grant("t3", 0, (i == 8) || (i == 17), !((i == 8) || (i == 17)));
      chk("t3_wdata", sram_wdata, ((i == 8) || (i == 17)) ? 32'h31313131 : 32'hF0F0F0F0);
      tick();
    end
    idle_inputs();

    // urgent read overrides rr=1; normal read then yields to the write
    rd_ren = 1; rd_raddr = 7'h10;
    exp_grant("t4a", 1, 0, 0);
    exp_q.push_back(ent(OWN_RD, 32'hA5A50010));
    tick();
    rd_rpri = PRI_URG; wr_wen = 1; wr_waddr = 7'h12; wr_wdata = 32'h12121212;
    exp_grant("t4b", 1, 0, 0);
    exp_q.push_back(ent(OWN_RD, 32'hA5A50010));
    tick();
    rd_rpri = PRI_NORM;
    exp_grant("t4c", 0, 1, 0);
    tick();
    exp_grant("t4d", 1, 0, 0);
    exp_q.push_back(ent(OWN_RD, 32'hA5A50010));
    tick();
    idle_inputs();

    // fetch read then rd read return on consecutive cycles
    fe_req = 1; fe_we = 0; fe_addr = 7'h40;
    exp_grant("t5a", 0, 0, 1);
    chk("t5a_we", sram_we, 0);
    exp_q.push_back(ent(OWN_FE, 32'h40404040));
    tick();
    fe_req = 0; rd_ren = 1; rd_raddr = 7'h41;
    exp_grant("t5b", 1, 0, 0);
    chk("t5b_fvalid", fe_rdata_valid, 1);
    chk("t5b_fdata", fe_rdata, 32'h40404040);
    exp_q.push_back(ent(OWN_RD, 32'h41414141));
    tick();
    rd_ren = 0;
    #1;
    chk("t5c_rvalid", rd_rdata_valid, 1);
    chk("t5c_rdata", rd_rdata, 32'h41414141);
    chk("t5c_fvalid", fe_rdata_valid, 0);

    // read the cycle after a write sees the new data
    wr_wen = 1; wr_waddr = 7'h50; wr_wdata = 32'h12345678;
    exp_grant("t5w", 0, 1, 0);
    tick();
    wr_wen = 0; rd_ren = 1; rd_raddr = 7'h50;
    exp_grant("t5r", 1, 0, 0);
    exp_q.push_back(ent(OWN_RD, 32'h12345678));
    tick();
    idle_inputs();

    // same-address rd+wr with rr=1: write first, read returns written data
    rd_ren = 1; rd_raddr = 7'h60; wr_wen = 1; wr_waddr = 7'h60; wr_wdata = 32'h60606060;
    exp_grant("t5s_w", 0, 1, 0);
    tick();
    wr_wen = 0;
    exp_grant("t5s_r", 1, 0, 0);
    exp_q.push_back(ent(OWN_RD, 32'h60606060));
    tick();
    idle_inputs();
    tick();

    // reset one cycle after a grant drops the in-flight rd_lat=2 read
    do_reset("rst2");
    rd_ren = 1; rd_raddr = 7'h25;
    #1;
    chk("t6_l2_grant", l2_rd_rready, 1);
    chk("t6_grant", rd_rready, 1);
    tick();
    rd_ren = 0;
    rst_n = 0;
    #1;
    chk_idle("t6_rst_a");
    tick();
    tick();
    chk_idle("t6_rst_b");
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_l2_rvalid", l2_rd_rdata_valid, 0);
      chk("t6_rvalid", rd_rdata_valid, 0);
    end
    rd_ren = 1; rd_raddr = 7'h25; wr_wen = 1; wr_waddr = 7'h26; wr_wdata = 32'h26262626;
    #1;
    chk("t6_rr_l2_rd", l2_rd_rready, 1);
    chk("t6_rr_l2_wr", l2_wr_wready, 0);
    exp_grant("t6_rr", 1, 0, 0);
    exp_q.push_back(ent(OWN_RD, 32'hDEADBEEF));
    tick();
    idle_inputs();
    tick();
    tick();
    chk("drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
